digital_trainer_kit: RTL and testbench

//   Digital-logic trainer for a TinyTapeout tile. Inputs A=ui_in[0] and B=ui_in[1]

---
 rtl/digital_trainer_kit.sv | 96 +++++++++
 tb/tb_digital_trainer_kit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/digital_trainer_kit.sv
// Digital-logic trainer tile: seven combinational gates on A/B, a JK flip-flop and an
// 8-bit lab register with selectable counter/shift/ring/Johnson/LFSR behaviour.
module digital_trainer_kit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [2:0] {
      ModeUp      = 3'b000,
      ModeDown    = 3'b001,
      ModeShift   = 3'b010,
      ModeRing    = 3'b011,
      ModeJohnson = 3'b100,
      ModeLfsr    = 3'b101,
      ModeHold    = 3'b110,
      ModeClear   = 3'b111
   } lab_mode_e;

   logic      a;
   logic      b;
   logic      si;
   logic      step_en;
   lab_mode_e mode;

   logic       jk_q;
   logic       jk_d;
   logic [7:0] s_q;
   logic [7:0] s_d;

   assign a       = ui_in[0];
   assign b       = ui_in[1];
   assign mode    = lab_mode_e'(ui_in[4:2]);
   assign si      = ui_in[5];
   assign step_en = ui_in[6];

   // Tile enable, bidirectional inputs and ui_in[7] carry no function.
   logic unused_inputs;
   assign unused_inputs = ^{ena, uio_in, ui_in[7]};

   always_comb begin
      jk_d = jk_q;
      unique case ({a, b})
         2'b00: jk_d = jk_q;
         2'b10: jk_d = 1'b1;
         2'b01: jk_d = 1'b0;
         2'b11: jk_d = ~jk_q;
      endcase
   end

   always_comb begin
      s_d = s_q;
      if (step_en) begin
         unique case (mode)
            ModeUp:      s_d = s_q + 8'd1;
            ModeDown:    s_d = s_q - 8'd1;
            ModeShift:   s_d = {s_q[6:0], si};
            // All-zero is a lock-up state for ring and LFSR, so seed a single one.
            ModeRing:    s_d = (s_q == 8'h00) ? 8'h01 : {s_q[6:0], s_q[7]};
            ModeJohnson: s_d = {s_q[6:0], ~s_q[7]};
            ModeLfsr:    s_d = (s_q == 8'h00) ? 8'h01
                                              : {s_q[6:0], s_q[7] ^ s_q[5] ^ s_q[4] ^ s_q[3]};
            ModeHold:    s_d = s_q;
            ModeClear:   s_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         jk_q <= 1'b0;
         s_q  <= 8'h00;
      end else begin
         jk_q <= jk_d;
         s_q  <= s_d;
      end
   end

   assign uo_out[0] = a & b;
   assign uo_out[1] = a | b;
   assign uo_out[2] = ~a;
   assign uo_out[3] = ~(a & b);
   assign uo_out[4] = ~(a | b);
   assign uo_out[5] = a ^ b;
   assign uo_out[6] = ~(a ^ b);
   assign uo_out[7] = jk_q;

   assign uio_out = s_q;
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_digital_trainer_kit.sv
// Scoreboard bench for digital_trainer_kit: stimulus queues expected outputs after each
// edge, a negedge monitor pops and compares them against the DUT.
module tb_digital_trainer_kit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   digital_trainer_kit dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] ui;
      logic [7:0] s_exp;
      logic       q_exp;
      logic       chk_s;
      logic       chk_q;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // Gate outputs bit6..bit0 indexed by {B,A}.
   logic [6:0] gate_tab [4] = '{7'b1011100, 7'b0101010, 7'b0101110, 7'b1000011};
   logic [7:0] john_tab [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

   // Stimulus state applied by step().
   logic       a_v = 0, b_v = 0, si_v = 0, en_v = 0, rst_v = 1;
   logic [2:0] mode_v = 3'b110;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   task automatic step(input string nm, input logic [7:0] s_exp, input logic q_exp,
                       input logic chk_s = 1'b1, input logic chk_q = 1'b1);
      exp_t e;
      @(negedge clk);
      #1;
      rst_n = rst_v;
      ui_in = {1'b0, en_v, si_v, mode_v, b_v, a_v};
      @(posedge clk);
      #1;
      e.name  = nm;
      e.ui    = ui_in;
      e.s_exp = s_exp;
      e.q_exp = q_exp;
      e.chk_s = chk_s;
      e.chk_q = chk_q;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic [1:0] ab;
      while (sb.size() > 0) begin
         e  = sb.pop_front();
         ab = e.ui[1:0];
         chk({e.name, " gates"}, {25'd0, uo_out[6:0]}, {25'd0, gate_tab[ab]});
         chk({e.name, " uio_oe"}, {24'd0, uio_oe}, 32'hFF);
         if (e.chk_q) chk({e.name, " jk_q"}, {31'd0, uo_out[7]}, {31'd0, e.q_exp});
         if (e.chk_s) chk({e.name, " lab_s"}, {24'd0, uio_out}, {24'd0, e.s_exp});
      end
   end

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return (s == 8'h00) ? 8'h01 : {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   task automatic do_reset();
      rst_v = 0; a_v = 0; b_v = 0; en_v = 0; si_v = 0; mode_v = 3'b110;
      step("reset", 8'h00, 1'b0);
      rst_v = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] s_m;
      bit         seen [256];
      int         distinct;

      // Gates without any reset; register state is unknown so only gates are checked.
      for (int i = 0; i < 4; i++) begin
         a_v = i[0]; b_v = i[1];
         step($sformatf("gate_ab%0d", i), 8'h00, 1'b0, 1'b0, 1'b0);
      end

      // JK sweep.
      do_reset();
      a_v = 1; b_v = 0; step("jk_set", 8'h00, 1'b1);
      a_v = 0; b_v = 1; step("jk_clr", 8'h00, 1'b0);
      a_v = 1; b_v = 1;
      step("jk_tog1", 8'h00, 1'b1);
      step("jk_tog2", 8'h00, 1'b0);
      step("jk_tog3", 8'h00, 1'b1);
      a_v = 0; b_v = 0;
      step("jk_hold1", 8'h00, 1'b1);
      step("jk_hold2", 8'h00, 1'b1);

      // Up counter full wrap, then down from 00, then frozen.
      do_reset();
      mode_v = 3'b000; en_v = 1;
      for (int k = 1; k <= 256; k++) step($sformatf("up_%0d", k), k[7:0], 1'b0);
      mode_v = 3'b001; step("down_wrap", 8'hFF, 1'b0);
      step("down_fe", 8'hFE, 1'b0);
      en_v = 0;
      for (int k = 0; k < 3; k++) step("frozen", 8'hFE, 1'b0);

      // Shift, ring, Johnson.
      do_reset();
      mode_v = 3'b010; en_v = 1; si_v = 1;
      step("shift1", 8'h01, 1'b0);
      step("shift2", 8'h03, 1'b0);
      step("shift3", 8'h07, 1'b0);
      si_v = 0; step("shift_si0", 8'h0E, 1'b0);
      do_reset();
      mode_v = 3'b011; en_v = 1;
      step("ring_seed", 8'h01, 1'b0);
      for (int k = 1; k < 8; k++) step($sformatf("ring_%0d", k), 8'h01 << k, 1'b0);
      step("ring_wrap", 8'h01, 1'b0);
      do_reset();
      mode_v = 3'b100; en_v = 1;
      for (int k = 0; k < 16; k++) step($sformatf("john_%0d", k), john_tab[k], 1'b0);
      step("john_again", 8'h01, 1'b0);

      // LFSR: model-predicted sequence, return to 01 after 255 more edges, no repeats.
      do_reset();
      mode_v = 3'b101; en_v = 1;
      s_m = 8'h00;
      distinct = 0;
      for (int k = 1; k <= 256; k++) begin
         s_m = lfsr_next(s_m);
         step($sformatf("lfsr_%0d", k), (k == 1 || k == 256) ? 8'h01 : s_m, 1'b0);
         if (k <= 255 && uio_out != 8'h00 && !seen[uio_out]) begin
            seen[uio_out] = 1'b1;
            distinct++;
         end
      end
      chk("lfsr_distinct", distinct, 255);

      // Reset mid-count with J set, then hold and clear modes.
      do_reset();
      mode_v = 3'b000; en_v = 1;
      for (int k = 1; k <= 8'h5A; k++) step("cnt_5a", k[7:0], 1'b0);
      a_v = 1; b_v = 0; en_v = 0; step("pre_rst_q", 8'h5A, 1'b1);
      rst_v = 0; a_v = 1; b_v = 1; en_v = 1; step("mid_reset", 8'h00, 1'b0);
      rst_v = 1; a_v = 0; b_v = 0;
      step("post_rst1", 8'h01, 1'b0);
      step("post_rst2", 8'h02, 1'b0);
      mode_v = 3'b110; step("hold_en", 8'h02, 1'b0);
      mode_v = 3'b111; step("clear", 8'h00, 1'b0);
      mode_v = 3'b001; step("after_clr", 8'hFF, 1'b0);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
